// File: rtl/field_lock_writer_if.sv
// ============================================================================
//  Module   : field_lock_writer_if
//  Purpose  : Lock request, status and playfield bus of the field lock writer.
//             Optional score signal present when FIELD_SCORE_EN is defined.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface field_lock_writer_if #(
    parameter int W = 20,
    parameter int H = 20
);
    logic             field_clear;
    logic             lock_req;
    logic [15:0]      block;
    logic [4:0]       block_pos_x;
    logic [4:0]       block_pos_y;
    logic [2:0]       rotate;
    logic             busy;
    logic             done;
    logic [4:0]       lines_cleared;
    logic             lock_oob;
    logic [W*H-1:0]   field;
`ifdef FIELD_SCORE_EN
    logic [15:0]      score;
`endif

    modport master (
        output field_clear, lock_req, block, block_pos_x, block_pos_y, rotate,
`ifdef FIELD_SCORE_EN
        input  score,
`endif
        input  busy, done, lines_cleared, lock_oob, field
    );

    modport slave (
        input  field_clear, lock_req, block, block_pos_x, block_pos_y, rotate,
`ifdef FIELD_SCORE_EN
        output score,
`endif
        output busy, done, lines_cleared, lock_oob, field
    );
endinterface

`default_nettype wire

// File: rtl/field_lock_writer.sv
// ============================================================================
//  Module   : field_lock_writer
//  Purpose  : Owns the playfield; merges a rotated 4x4 piece one cell per
//             cycle, then removes full rows bottom-up. Macro FIELD_SCORE_EN
//             adds a saturating score output.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module field_lock_writer #(
    parameter int W = 20,
    parameter int H = 20
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    field_lock_writer_if.slave bus
);
    localparam int N     = W * H;
    localparam int IDX_W = $clog2(N);
    localparam int ROW_W = $clog2(H);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_MERGE = 2'd1,
        S_SCAN  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic [15:0]        blk_q, blk_d;
    logic [4:0]         px_q, px_d;
    logic [4:0]         py_q, py_d;
    logic [1:0]         rot_q, rot_d;
    logic [N-1:0]       field_q, field_d;
    logic [4:0]         lines_q, lines_d;
    logic               oob_q, oob_d;

    logic [1:0]         w_bx, w_by;
    logic [3:0]         w_src;
    logic               w_src_bit;
    logic [5:0]         w_tx, w_ty;
    logic               w_in_bounds;
    logic [IDX_W-1:0]   w_idx;
    logic [W-1:0]       w_row;
    logic               w_row_full;
    logic               w_unused_rot;

    // Only rotate%4 matters; the top bit is intentionally dropped.
    assign w_unused_rot = bus.rotate[2];

    assign w_bx = cnt_q[1:0];
    assign w_by = cnt_q[3:2];

    // Source bit of the rotation-0 bitmap that lands on target cell (bx,by).
    always_comb begin
        w_src = 4'd0;
        case (rot_q)
            2'd0: w_src = {w_by, w_bx};
            2'd1: w_src = 4'd12 + {2'b00, w_by} - {w_bx, 2'b00};
            2'd2: w_src = 4'd15 - {w_by, 2'b00} - {2'b00, w_bx};
            2'd3: w_src = 4'd3 - {2'b00, w_by} + {w_bx, 2'b00};
            default: w_src = 4'd0;
        endcase
    end

    assign w_src_bit   = blk_q[w_src];
    assign w_tx        = {1'b0, px_q} + {4'b0000, w_bx};
    assign w_ty        = {1'b0, py_q} + {4'b0000, w_by};
    assign w_in_bounds = (w_tx < 6'(W)) && (w_ty < 6'(H));
    assign w_idx       = IDX_W'(w_ty) * IDX_W'(W) + IDX_W'(w_tx);

    assign w_row      = field_q[int'(row_q)*W +: W];
    assign w_row_full = &w_row;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        row_d   = row_q;
        blk_d   = blk_q;
        px_d    = px_q;
        py_d    = py_q;
        rot_d   = rot_q;
        field_d = field_q;
        lines_d = lines_q;
        oob_d   = oob_q;

        case (state_q)
            S_IDLE: begin
                if (bus.lock_req) begin
                    blk_d   = bus.block;
                    px_d    = bus.block_pos_x;
                    py_d    = bus.block_pos_y;
                    rot_d   = bus.rotate[1:0];
                    lines_d = 5'd0;
                    oob_d   = 1'b0;
                    cnt_d   = 4'd0;
                    state_d = S_MERGE;
                end
            end
            S_MERGE: begin
                if (w_src_bit) begin
                    if (w_in_bounds) begin
                        field_d[w_idx] = 1'b1;
                    end else begin
                        oob_d = 1'b1;
                    end
                end
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd15) begin
                    state_d = S_SCAN;
                    row_d   = ROW_W'(H - 1);
                end
            end
            S_SCAN: begin
                if (w_row_full) begin
                    // Collapse rows 0..r down by one; r stays to recheck the new row.
                    for (int k = 1; k < H; k++) begin
                        if (k <= int'(row_q)) begin
                            field_d[k*W +: W] = field_q[(k-1)*W +: W];
                        end
                    end
                    field_d[W-1:0] = '0;
                    lines_d        = lines_q + 5'd1;
                end else if (row_q == '0) begin
                    state_d = S_DONE;
                end else begin
                    row_d = row_q - ROW_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (bus.field_clear) begin
            field_d = '0;
            lines_d = 5'd0;
            oob_d   = 1'b0;
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            row_q   <= '0;
            blk_q   <= 16'd0;
            px_q    <= 5'd0;
            py_q    <= 5'd0;
            rot_q   <= 2'd0;
            field_q <= '0;
            lines_q <= 5'd0;
            oob_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            row_q   <= row_d;
            blk_q   <= blk_d;
            px_q    <= px_d;
            py_q    <= py_d;
            rot_q   <= rot_d;
            field_q <= field_d;
            lines_q <= lines_d;
            oob_q   <= oob_d;
        end
    end

`ifdef FIELD_SCORE_EN
    logic [15:0] score_q, score_d;
    logic [15:0] w_pts;
    logic [16:0] w_sum;

    always_comb begin
        w_pts = 16'd0;
        case (lines_q)
            5'd0:    w_pts = 16'd0;
            5'd1:    w_pts = 16'd1;
            5'd2:    w_pts = 16'd3;
            5'd3:    w_pts = 16'd5;
            // 8 for four lines plus 8 per extra line == 8*(n-3)
            default: w_pts = (16'(lines_q) - 16'd3) << 3;
        endcase
    end

    assign w_sum = {1'b0, score_q} + {1'b0, w_pts};

    always_comb begin
        score_d = score_q;
        if (state_q == S_DONE) begin
            score_d = w_sum[16] ? 16'hFFFF : w_sum[15:0];
        end
        if (bus.field_clear) begin
            score_d = 16'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            score_q <= 16'd0;
        end else begin
            score_q <= score_d;
        end
    end

    assign bus.score = score_q;
`endif

    assign bus.busy          = (state_q != S_IDLE);
    assign bus.done          = (state_q == S_DONE);
    assign bus.lines_cleared = lines_q;
    assign bus.lock_oob      = oob_q;
    assign bus.field         = field_q;

endmodule

`default_nettype wire

// File: tb/tb_field_lock_writer.sv
// ============================================================================
//  Module   : tb_field_lock_writer
//  Purpose  : Directed self-checking bench for field_lock_writer.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_field_lock_writer;
    localparam int W = 20;
    localparam int H = 20;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_fail;

    field_lock_writer_if #(.W(W), .H(H)) bus ();

    field_lock_writer #(.W(W), .H(H)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [399:0] got, input logic [399:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic start_lock(input logic [15:0] blk, input logic [4:0] x,
                              input logic [4:0] y, input logic [2:0] rot);
        bus.block       = blk;
        bus.block_pos_x = x;
        bus.block_pos_y = y;
        bus.rotate      = rot;
        bus.lock_req    = 1'b1;
        tick();
        bus.lock_req    = 1'b0;
        bus.block       = 16'hFFFF;
        bus.block_pos_x = 5'd7;
        bus.block_pos_y = 5'd7;
        bus.rotate      = 3'd2;
    endtask

    // Returns the cycle number (cycle 1 follows the sampling edge) in which done is high.
    task automatic wait_done(input int start_cyc, output int lat);
        int cyc;
        cyc = start_cyc;
        while (!bus.done && cyc < 300) begin
            tick();
            cyc++;
        end
        lat = bus.done ? cyc : -1;
    endtask

    task automatic do_lock(input logic [15:0] blk, input logic [4:0] x,
                           input logic [4:0] y, input logic [2:0] rot, output int lat);
        start_lock(blk, x, y, rot);
        wait_done(1, lat);
        tick();
    endtask

    task automatic clear_field();
        bus.field_clear = 1'b1;
        tick();
        bus.field_clear = 1'b0;
    endtask

    task automatic expect_no_done(input string tag, input int cycles);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (bus.done) seen = 1'b1;
        end
        chk(tag, 400'(seen), 400'(0));
    endtask

    initial begin
        logic [399:0] e;
        int lat;

        n_cmp  = 0;
        n_fail = 0;
        rst_n           = 1'b0;
        bus.field_clear = 1'b0;
        bus.lock_req    = 1'b0;
        bus.block       = 16'd0;
        bus.block_pos_x = 5'd0;
        bus.block_pos_y = 5'd0;
        bus.rotate      = 3'd0;
        tick();
        tick();
        chk("rst_field", bus.field, 400'(0));
        chk("rst_busy", 400'(bus.busy), 400'(0));
        chk("rst_done", 400'(bus.done), 400'(0));
        chk("rst_lines", 400'(bus.lines_cleared), 400'(0));
        chk("rst_oob", 400'(bus.lock_oob), 400'(0));
        rst_n = 1'b1;
        tick();

        // Place a 2x2 square in the bottom-left corner
        do_lock(16'h0033, 5'd0, 5'd18, 3'd0, lat);
        e = '0; e[360] = 1'b1; e[361] = 1'b1; e[380] = 1'b1; e[381] = 1'b1;
        chk("place_field", bus.field, e);
        chk("place_lat", 400'(lat), 400'(37));
        chk("place_lines", 400'(bus.lines_cleared), 400'(0));
        chk("place_oob", 400'(bus.lock_oob), 400'(0));
        chk("place_idle", 400'(bus.busy), 400'(0));

        // Rotation 1 and 5 give a vertical bar in column 3
        clear_field();
        chk("clear_field", bus.field, 400'(0));
        do_lock(16'h000F, 5'd0, 5'd0, 3'd1, lat);
        e = '0; e[3] = 1'b1; e[23] = 1'b1; e[43] = 1'b1; e[63] = 1'b1;
        chk("rot1_field", bus.field, e);
        clear_field();
        do_lock(16'h000F, 5'd0, 5'd0, 3'd5, lat);
        chk("rot5_field", bus.field, e);

        // Rotation 2 of an L-ish shape: bit0 lands at (3,3), bit1 at (2,3)
        clear_field();
        do_lock(16'h0013, 5'd0, 5'd0, 3'd2, lat);
        e = '0; e[63] = 1'b1; e[62] = 1'b1; e[43] = 1'b1;
        chk("rot2_field", bus.field, e);

        // Fill the bottom row with five bars
        clear_field();
        for (int i = 0; i < 4; i++) begin
            do_lock(16'h000F, 5'(i*4), 5'd19, 3'd0, lat);
        end
        e = '0; e[395:380] = 16'hFFFF;
        chk("row_partial", bus.field, e);
        do_lock(16'h000F, 5'd16, 5'd19, 3'd0, lat);
        chk("lc_field", bus.field, 400'(0));
        chk("lc_lines", 400'(bus.lines_cleared), 400'(1));
        chk("lc_lat", 400'(lat), 400'(38));
        tick();
        chk("lc_lines_held", 400'(bus.lines_cleared), 400'(1));
`ifdef FIELD_SCORE_EN
        chk("lc_score", 400'(bus.score), 400'(1));
`endif

        // Row 18 contents shift down when row 19 is cleared
        clear_field();
        do_lock(16'h000F, 5'd0, 5'd18, 3'd0, lat);
        for (int i = 0; i < 5; i++) begin
            do_lock(16'h000F, 5'(i*4), 5'd19, 3'd0, lat);
        end
        e = '0; e[383:380] = 4'hF;
        chk("shift_field", bus.field, e);
        chk("shift_lines", 400'(bus.lines_cleared), 400'(1));

        // Out-of-bounds cells are dropped and flagged
        clear_field();
        do_lock(16'h000F, 5'd18, 5'd0, 3'd0, lat);
        e = '0; e[18] = 1'b1; e[19] = 1'b1;
        chk("oob_field", bus.field, e);
        chk("oob_flag", 400'(bus.lock_oob), 400'(1));
        clear_field();
        do_lock(16'h000F, 5'd31, 5'd0, 3'd0, lat);
        chk("oob31_field", bus.field, 400'(0));
        chk("oob31_flag", 400'(bus.lock_oob), 400'(1));
        do_lock(16'h0001, 5'd0, 5'd0, 3'd0, lat);
        chk("oob_cleared_on_accept", 400'(bus.lock_oob), 400'(0));

        // lock_req during MERGE is ignored
        clear_field();
        start_lock(16'h0033, 5'd0, 5'd0, 3'd0);
        tick();
        tick();
        bus.block    = 16'hFFFF;
        bus.lock_req = 1'b1;
        tick();
        bus.lock_req = 1'b0;
        chk("merge_busy", 400'(bus.busy), 400'(1));
        wait_done(4, lat);
        chk("merge_ign_lat", 400'(lat), 400'(37));
        tick();
        e = '0; e[0] = 1'b1; e[1] = 1'b1; e[20] = 1'b1; e[21] = 1'b1;
        chk("merge_ign_field", bus.field, e);

        // field_clear during MERGE cycle 5 aborts the lock
        clear_field();
        start_lock(16'h0033, 5'd0, 5'd0, 3'd0);
        for (int i = 1; i < 5; i++) tick();
        chk("merge_progress", 400'(bus.field[1:0]), 400'(3));
        clear_field();
        chk("abort_field", bus.field, 400'(0));
        chk("abort_busy", 400'(bus.busy), 400'(0));
        expect_no_done("abort_no_done", 50);

        // field_clear and lock_req together: request dropped
        bus.field_clear = 1'b1;
        bus.lock_req    = 1'b1;
        tick();
        bus.field_clear = 1'b0;
        bus.lock_req    = 1'b0;
        chk("clr_req_busy", 400'(bus.busy), 400'(0));

        // Asynchronous reset during SCAN
        start_lock(16'h000F, 5'd18, 5'd19, 3'd0);
        for (int i = 1; i < 20; i++) tick();
        chk("scan_busy", 400'(bus.busy), 400'(1));
        rst_n = 1'b0;
        #1;
        chk("arst_field", bus.field, 400'(0));
        chk("arst_busy", 400'(bus.busy), 400'(0));
        chk("arst_done", 400'(bus.done), 400'(0));
        chk("arst_oob", 400'(bus.lock_oob), 400'(0));
        tick();
        rst_n = 1'b1;
        expect_no_done("arst_no_done", 50);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
